// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read engine between two descriptor-driven clients.
// Optional DRAM_ARB_CHUNK_EN caps each reader command at CHUNK_BYTES and re-arbitrates per chunk.
module dram_read_arbiter #(
    parameter int CHUNK_BYTES = 2048
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        C0_CONFIG_VALID,
    output logic        C0_CONFIG_READY,
    input  logic [31:0] C0_CONFIG_START_ADDR,
    input  logic [31:0] C0_CONFIG_NBYTES,
    input  logic        C0_DATA_READY_DOWNSTREAM,
    output logic        C0_DATA_VALID,
    output logic [63:0] C0_DATA,
    input  logic        C1_CONFIG_VALID,
    output logic        C1_CONFIG_READY,
    input  logic [31:0] C1_CONFIG_START_ADDR,
    input  logic [31:0] C1_CONFIG_NBYTES,
    input  logic        C1_DATA_READY_DOWNSTREAM,
    output logic        C1_DATA_VALID,
    output logic [63:0] C1_DATA,
    output logic        R_CONFIG_VALID,
    input  logic        R_CONFIG_READY,
    output logic [31:0] R_CONFIG_START_ADDR,
    output logic [31:0] R_CONFIG_NBYTES,
    output logic        R_DATA_READY_DOWNSTREAM,
    input  logic        R_DATA_VALID,
    input  logic [63:0] R_DATA,
    output logic        BUSY,
    output logic        GRANT
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_STREAM} state_t;

    generate
        if (CHUNK_BYTES < 128 || (CHUNK_BYTES % 128) != 0) begin : g_bad_chunk
            $error("CHUNK_BYTES must be a multiple of 128 and at least 128");
        end
    endgenerate

    logic [1:0]  cfg_valid;
    logic [1:0]  cfg_ready;
    logic [1:0]  ds_ready;
    logic [1:0]  data_valid;
    logic [31:0] cfg_addr   [2];
    logic [31:0] cfg_nbytes [2];

    assign cfg_valid     = {C1_CONFIG_VALID, C0_CONFIG_VALID};
    assign ds_ready      = {C1_DATA_READY_DOWNSTREAM, C0_DATA_READY_DOWNSTREAM};
    assign cfg_addr[0]   = C0_CONFIG_START_ADDR;
    assign cfg_addr[1]   = C1_CONFIG_START_ADDR;
    assign cfg_nbytes[0] = C0_CONFIG_NBYTES;
    assign cfg_nbytes[1] = C1_CONFIG_NBYTES;

    state_t      state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic [31:0] addr_q [2];
    logic [31:0] addr_d [2];
    logic [31:0] rem_q  [2];
    logic [31:0] rem_d  [2];
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [31:0] r_nbytes_q, r_nbytes_d;
    logic [28:0] beat_cnt_q, beat_cnt_d;

    logic        grant_sel;
    logic [31:0] chunk;
    logic        streaming;
    logic        beat_fire;

    // Alternate on a tie; otherwise the sole pending client wins.
    assign grant_sel = (&pend_q) ? ~last_grant_q : pend_q[1];

`ifdef DRAM_ARB_CHUNK_EN
    localparam logic [31:0] CHUNK_W = 32'(CHUNK_BYTES);
    assign chunk = (rem_q[grant_sel] > CHUNK_W) ? CHUNK_W : rem_q[grant_sel];
`else
    assign chunk = rem_q[grant_sel];
`endif

    assign streaming               = (state_q == ST_STREAM);
    assign R_DATA_READY_DOWNSTREAM = streaming && ds_ready[grant_q];
    assign beat_fire               = R_DATA_VALID && R_DATA_READY_DOWNSTREAM;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_client
            assign cfg_ready[gi]  = !pend_q[gi];
            assign data_valid[gi] = streaming && (grant_q == 1'(gi)) && R_DATA_VALID;
        end
    endgenerate

    assign C0_CONFIG_READY     = cfg_ready[0];
    assign C1_CONFIG_READY     = cfg_ready[1];
    assign C0_DATA_VALID       = data_valid[0];
    assign C1_DATA_VALID       = data_valid[1];
    assign C0_DATA             = R_DATA;
    assign C1_DATA             = R_DATA;
    assign R_CONFIG_VALID      = (state_q == ST_ISSUE);
    assign R_CONFIG_START_ADDR = r_addr_q;
    assign R_CONFIG_NBYTES     = r_nbytes_q;
    assign BUSY                = (state_q != ST_IDLE);
    assign GRANT               = grant_q;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        r_addr_d     = r_addr_q;
        r_nbytes_d   = r_nbytes_q;
        beat_cnt_d   = beat_cnt_q;

        // A descriptor shorter than one burst is acknowledged but never becomes pending.
        for (int n = 0; n < 2; n++) begin
            if (cfg_valid[n] && cfg_ready[n]) begin
                addr_d[n] = cfg_addr[n];
                rem_d[n]  = {cfg_nbytes[n][31:7], 7'b0};
                pend_d[n] = |cfg_nbytes[n][31:7];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    grant_d    = grant_sel;
                    r_addr_d   = addr_q[grant_sel];
                    r_nbytes_d = chunk;
                    beat_cnt_d = 29'(chunk >> 3);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (R_CONFIG_READY) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q - 29'd1;
                    if (beat_cnt_q == 29'd1) begin
                        state_d          = ST_IDLE;
                        addr_d[grant_q]  = addr_q[grant_q] + r_nbytes_q;
                        rem_d[grant_q]   = rem_q[grant_q] - r_nbytes_q;
                        pend_d[grant_q]  = (rem_q[grant_q] != r_nbytes_q);
                        last_grant_d     = grant_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            addr_q       <= '{default: '0};
            rem_q        <= '{default: '0};
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            r_addr_q     <= '0;
            r_nbytes_q   <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            r_addr_q     <= r_addr_d;
            r_nbytes_q   <= r_nbytes_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Scoreboard bench for dram_read_arbiter: expected reader commands and per-client beats are
// queued by the stimulus; a negedge monitor pops and compares whatever the DUT presents.
module tb_dram_read_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        ARESETN;
    logic        C0_CONFIG_VALID, C0_CONFIG_READY, C0_DATA_READY_DOWNSTREAM, C0_DATA_VALID;
    logic [31:0] C0_CONFIG_START_ADDR, C0_CONFIG_NBYTES;
    logic [63:0] C0_DATA;
    logic        C1_CONFIG_VALID, C1_CONFIG_READY, C1_DATA_READY_DOWNSTREAM, C1_DATA_VALID;
    logic [31:0] C1_CONFIG_START_ADDR, C1_CONFIG_NBYTES;
    logic [63:0] C1_DATA;
    logic        R_CONFIG_VALID, R_CONFIG_READY, R_DATA_READY_DOWNSTREAM, R_DATA_VALID;
    logic [31:0] R_CONFIG_START_ADDR, R_CONFIG_NBYTES;
    logic [63:0] R_DATA;
    logic        BUSY, GRANT;

    dram_read_arbiter #(.CHUNK_BYTES(512)) dut (
        .ACLK(clk), .ARESETN(ARESETN),
        .C0_CONFIG_VALID(C0_CONFIG_VALID), .C0_CONFIG_READY(C0_CONFIG_READY),
        .C0_CONFIG_START_ADDR(C0_CONFIG_START_ADDR), .C0_CONFIG_NBYTES(C0_CONFIG_NBYTES),
        .C0_DATA_READY_DOWNSTREAM(C0_DATA_READY_DOWNSTREAM), .C0_DATA_VALID(C0_DATA_VALID),
        .C0_DATA(C0_DATA),
        .C1_CONFIG_VALID(C1_CONFIG_VALID), .C1_CONFIG_READY(C1_CONFIG_READY),
        .C1_CONFIG_START_ADDR(C1_CONFIG_START_ADDR), .C1_CONFIG_NBYTES(C1_CONFIG_NBYTES),
        .C1_DATA_READY_DOWNSTREAM(C1_DATA_READY_DOWNSTREAM), .C1_DATA_VALID(C1_DATA_VALID),
        .C1_DATA(C1_DATA),
        .R_CONFIG_VALID(R_CONFIG_VALID), .R_CONFIG_READY(R_CONFIG_READY),
        .R_CONFIG_START_ADDR(R_CONFIG_START_ADDR), .R_CONFIG_NBYTES(R_CONFIG_NBYTES),
        .R_DATA_READY_DOWNSTREAM(R_DATA_READY_DOWNSTREAM), .R_DATA_VALID(R_DATA_VALID),
        .R_DATA(R_DATA),
        .BUSY(BUSY), .GRANT(GRANT)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] nbytes;
        logic        g;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [63:0] exp_beat0[$];
    logic [63:0] exp_beat1[$];
    int          errors = 0;
    int          checks = 0;
    int          beats[2] = '{0, 0};
    int          mode = 0;
    logic        rd_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_cmd(input logic [31:0] a, input logic [31:0] nb, input logic g);
        cmd_t c;
        logic [31:0] ba;
        c.addr = a; c.nbytes = nb; c.g = g;
        exp_cmd.push_back(c);
        for (int i = 0; i < int'(nb >> 3); i++) begin
            ba = a + 32'(i * 8);
            if (g) exp_beat1.push_back({32'hDA7A0000, ba});
            else   exp_beat0.push_back({32'hDA7A0000, ba});
        end
    endtask

    // Reader model: accepts one command when idle, returns one beat per accepted cycle.
    initial begin : reader_model
        logic        s_cmd, s_beat, s_rst;
        logic [31:0] s_addr, s_nb, rd_addr;
        int          rd_left;
        rd_addr = '0; rd_left = 0;
        R_CONFIG_READY = 1'b1; R_DATA_VALID = 1'b0; R_DATA = '0;
        C0_DATA_READY_DOWNSTREAM = 1'b1; C1_DATA_READY_DOWNSTREAM = 1'b1;
        forever begin
            @(negedge clk);
            s_cmd  = R_CONFIG_VALID && R_CONFIG_READY;
            s_beat = R_DATA_VALID && R_DATA_READY_DOWNSTREAM;
            s_rst  = ARESETN;
            s_addr = R_CONFIG_START_ADDR;
            s_nb   = R_CONFIG_NBYTES;
            @(posedge clk);
            #1;
            if (!s_rst) begin
                rd_busy = 1'b0;
            end else begin
                if (s_beat) begin
                    rd_addr = rd_addr + 32'd8;
                    rd_left--;
                    if (rd_left == 0) rd_busy = 1'b0;
                end
                if (s_cmd) begin
                    rd_busy = 1'b1;
                    rd_addr = s_addr;
                    rd_left = int'(s_nb >> 3);
                end
            end
            R_CONFIG_READY = !rd_busy;
            R_DATA_VALID   = rd_busy;
            R_DATA         = {32'hDA7A0000, rd_addr};
            C0_DATA_READY_DOWNSTREAM = (mode == 1) ? ~C0_DATA_READY_DOWNSTREAM : 1'b1;
            C1_DATA_READY_DOWNSTREAM = 1'b1;
        end
    end

    // Monitor: reader commands, client beats and data-path steering.
    always @(negedge clk) begin
        cmd_t        c;
        logic [63:0] b;
        if (R_CONFIG_VALID && R_CONFIG_READY) begin
            if (exp_cmd.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_cmd: got addr=%0h nbytes=%0h expected none",
                         R_CONFIG_START_ADDR, R_CONFIG_NBYTES);
            end else begin
                c = exp_cmd.pop_front();
                $display("cmd addr=%08h nbytes=%0d grant=%0d", R_CONFIG_START_ADDR,
                         R_CONFIG_NBYTES, GRANT);
                chk("cmd_addr", R_CONFIG_START_ADDR, c.addr);
                chk("cmd_nbytes", R_CONFIG_NBYTES, c.nbytes);
                chk("cmd_grant", GRANT, c.g);
            end
        end
        if (C0_DATA_VALID && C0_DATA_READY_DOWNSTREAM) begin
            beats[0]++;
            if (exp_beat0.size() == 0) chk("c0_unexpected_beat", C0_DATA, 64'hX);
            else begin b = exp_beat0.pop_front(); chk("c0_beat", C0_DATA, b); end
        end
        if (C1_DATA_VALID && C1_DATA_READY_DOWNSTREAM) begin
            beats[1]++;
            if (exp_beat1.size() == 0) chk("c1_unexpected_beat", C1_DATA, 64'hX);
            else begin b = exp_beat1.pop_front(); chk("c1_beat", C1_DATA, b); end
        end
        if (rd_busy) begin
            chk("r_ready_mirror", R_DATA_READY_DOWNSTREAM,
                GRANT ? C1_DATA_READY_DOWNSTREAM : C0_DATA_READY_DOWNSTREAM);
            chk("granted_valid", GRANT ? C1_DATA_VALID : C0_DATA_VALID, R_DATA_VALID);
            chk("ungranted_valid", GRANT ? C0_DATA_VALID : C1_DATA_VALID, 0);
        end else begin
            chk("idle_datapath", {R_DATA_READY_DOWNSTREAM, C0_DATA_VALID, C1_DATA_VALID}, 0);
        end
    end

    task automatic check_reset_values();
        chk("rst_c0_cfg_ready", C0_CONFIG_READY, 1);
        chk("rst_c1_cfg_ready", C1_CONFIG_READY, 1);
        chk("rst_r_cfg_valid", R_CONFIG_VALID, 0);
        chk("rst_r_addr", R_CONFIG_START_ADDR, 0);
        chk("rst_r_nbytes", R_CONFIG_NBYTES, 0);
        chk("rst_r_ready_ds", R_DATA_READY_DOWNSTREAM, 0);
        chk("rst_data_valid", {C0_DATA_VALID, C1_DATA_VALID}, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_grant", GRANT, 0);
    endtask

    task automatic post(input int n, input logic [31:0] a, input logic [31:0] nb);
        bit ok = 0;
        @(posedge clk); #1;
        if (n == 0) begin
            C0_CONFIG_VALID = 1; C0_CONFIG_START_ADDR = a; C0_CONFIG_NBYTES = nb;
        end else begin
            C1_CONFIG_VALID = 1; C1_CONFIG_START_ADDR = a; C1_CONFIG_NBYTES = nb;
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (n == 0) ? C0_CONFIG_READY : C1_CONFIG_READY;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL post_timeout: got client %0d never ready expected ready", n);
        end
        @(posedge clk); #1;
        C0_CONFIG_VALID = 0; C1_CONFIG_VALID = 0;
        $display("post client=%0d addr=%08h nbytes=%0d", n, a, nb);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = !BUSY && !rd_busy && exp_cmd.size() == 0 &&
                 exp_beat0.size() == 0 && exp_beat1.size() == 0;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got %0d cmds %0d/%0d beats pending expected 0",
                     exp_cmd.size(), exp_beat0.size(), exp_beat1.size());
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 ARESETN = 0;
        @(posedge clk); #1 ARESETN = 1;
        exp_cmd.delete(); exp_beat0.delete(); exp_beat1.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  seen, b0, b1;
        bit  ok;
        ARESETN = 0;
        C0_CONFIG_VALID = 0; C0_CONFIG_START_ADDR = '0; C0_CONFIG_NBYTES = '0;
        C1_CONFIG_VALID = 0; C1_CONFIG_START_ADDR = '0; C1_CONFIG_NBYTES = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1 ARESETN = 1;

        // Single 256-byte descriptor on client 0.
        expect_cmd(32'h1000, 32'd256, 1'b0);
        post(0, 32'h1000, 32'd256);
        seen = 0;
        for (int i = 0; i < 300 && seen < 32; i++) begin
            @(negedge clk);
            if (C0_DATA_VALID && C0_DATA_READY_DOWNSTREAM) seen++;
        end
        chk("s1_beats_seen", seen, 32);
        chk("s1_ready_during_last", C0_CONFIG_READY, 0);
        @(negedge clk);
        chk("s1_ready_after_last", C0_CONFIG_READY, 1);
        chk("s1_busy_after_last", BUSY, 0);
        wait_idle(50);

        // Simultaneous descriptors right after reset: client 0 wins the first tie.
        pulse_reset();
        expect_cmd(32'h3000, 32'd128, 1'b0);
        expect_cmd(32'h4000, 32'd128, 1'b1);
        @(posedge clk); #1;
        C0_CONFIG_VALID = 1; C0_CONFIG_START_ADDR = 32'h3000; C0_CONFIG_NBYTES = 32'd128;
        C1_CONFIG_VALID = 1; C1_CONFIG_START_ADDR = 32'h4000; C1_CONFIG_NBYTES = 32'd128;
        @(posedge clk); #1;
        C0_CONFIG_VALID = 0; C1_CONFIG_VALID = 0;
        $display("post both c0=3000 c1=4000 nbytes=128");
        wait_idle(300);

        // Sub-burst length is acknowledged and dropped.
        post(1, 32'h5000, 32'd100);
        repeat (8) begin
            @(negedge clk);
            chk("s3_busy", BUSY, 0);
            chk("s3_r_cfg_valid", R_CONFIG_VALID, 0);
        end
        chk("s3_c1_cfg_ready", C1_CONFIG_READY, 1);

        // Client 0 back-pressure toggling every cycle.
        b0 = beats[0]; b1 = beats[1];
        mode = 1;
        expect_cmd(32'h6000, 32'd128, 1'b0);
        post(0, 32'h6000, 32'd128);
        wait_idle(300);
        mode = 0;
        chk("s4_c0_beats", beats[0] - b0, 16);
        chk("s4_c1_beats", beats[1] - b1, 0);

        // Long descriptor crossing the top of the address space, second client joins mid-way.
`ifdef DRAM_ARB_CHUNK_EN
        expect_cmd(32'hFFFFFE00, 32'd512, 1'b0);
        expect_cmd(32'h00002000, 32'd512, 1'b1);
        expect_cmd(32'h00000000, 32'd512, 1'b0);
        expect_cmd(32'h00000200, 32'd256, 1'b0);
`else
        expect_cmd(32'hFFFFFE00, 32'd1280, 1'b0);
        expect_cmd(32'h00002000, 32'd512, 1'b1);
`endif
        post(0, 32'hFFFFFE00, 32'd1280);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = BUSY;
        end
        chk("s5_busy_seen", ok, 1);
        post(1, 32'h2000, 32'd512);
        wait_idle(2000);

        // Reset pulse in the middle of a transfer.
        expect_cmd(32'h7000, 32'd256, 1'b0);
        post(0, 32'h7000, 32'd256);
        b0 = beats[0];
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (beats[0] - b0) >= 5;
        end
        chk("s6_beats_before_reset", ok, 1);
        pulse_reset();
        @(negedge clk);
        check_reset_values();
        repeat (6) begin
            @(negedge clk);
            chk("s6_no_cmd_after_reset", R_CONFIG_VALID, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
